// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Pixel-clock-domain reader for a 16-bit RGB565 first-word-fall-through FIFO.
// Generates fixed 640x480@60 timing (800x525 total), pops one word per visible
// pixel, and drives registered rgb/hsync/vsync/de. vtrigger pulses once per
// frame to ask the producer for the next frame. An empty FIFO on a visible
// pixel is masked with UNDERFLOW_COLOR. The FIFO is drained during vertical
// blanking so the producer realigns every frame.
//
// Optional feature (compile-time macro VGA_SCANOUT_STATS_EN):
//   defined     - underflow_count counts underflow pulses, saturating at FFFF,
//                 and is cleared only by reset.
//   not defined - underflow_count is tied to 0.
//
// Parameters
//   UNDERFLOW_COLOR  RGB565 colour shown on an underflowed pixel
//   VTRIG_LINE       line on which vtrigger fires at hcount 0 (481..524)
//
// Ports
//   clk              in   pixel clock, sole clock
//   reset_n          in   asynchronous active-low reset
//   fifo_data[15:0]  in   FIFO head word, valid while fifo_empty = 0
//   fifo_empty       in   FIFO empty flag
//   fifo_read        out  pop strobe
//   rgb[15:0]        out  pixel {R[15:11], G[10:5], B[4:0]}
//   hsync            out  horizontal sync, active-low
//   vsync            out  vertical sync, active-low
//   de               out  data enable, high in the visible area
//   vtrigger         out  one-cycle frame request pulse
//   underflow        out  one-cycle pulse per underflowed pixel
//   underflow_count  out  saturating underflow counter
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter logic [15:0] UNDERFLOW_COLOR = 16'hF81F,
    parameter int          VTRIG_LINE      = 524
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic [15:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        vtrigger,
    output logic        underflow,
    output logic [15:0] underflow_count
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;
    localparam logic [9:0] V_TRIG       = 10'(VTRIG_LINE);

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_run;
    logic [15:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_vtrigger;
    logic        r_underflow;

    logic        w_active;
    logic        w_drain;
    logic        w_underflow_next;

    assign w_active = (r_hcount < H_VISIBLE) && (r_vcount < V_VISIBLE);
    // Drain stops at VTRIG_LINE so words written after vtrigger are kept.
    assign w_drain  = (r_vcount >= V_VISIBLE) && (r_vcount < V_TRIG);

    // Pop handshake: the head word is consumed on the rising edge where
    // fifo_read = 1; fifo_read is only ever raised while fifo_empty = 0, and
    // the data sampled into rgb on that same edge is the popped word.
    assign fifo_read = r_run && !fifo_empty && (w_active || w_drain);

    assign w_underflow_next = r_run && w_active && fifo_empty;

    // Counters start at the top of vertical blanking so the very first frame
    // is requested before any visible pixel is due.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= 10'd0;
            r_vcount <= V_VISIBLE;
        end else if (r_hcount == H_LAST) begin
            r_hcount <= 10'd0;
            r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // All video outputs register from the same counter state so they stay
    // mutually aligned one clock behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb       <= 16'h0000;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_de        <= 1'b0;
            r_vtrigger  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_active) begin
                r_rgb <= fifo_empty ? UNDERFLOW_COLOR : fifo_data;
            end else begin
                r_rgb <= 16'h0000;
            end
            r_hsync     <= !((r_hcount >= H_SYNC_START) && (r_hcount <= H_SYNC_END));
            r_vsync     <= !((r_vcount >= V_SYNC_START) && (r_vcount <= V_SYNC_END));
            r_de        <= w_active;
            r_vtrigger  <= r_run && (r_hcount == 10'd0) && (r_vcount == V_TRIG);
            r_underflow <= w_underflow_next;
        end
    end

    assign rgb       = r_rgb;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign vtrigger  = r_vtrigger;
    assign underflow = r_underflow;

`ifdef VGA_SCANOUT_STATS_EN
    logic [15:0] r_underflow_count;

    // Updated on the same edge that raises the underflow pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow_count <= 16'h0000;
        end else if (w_underflow_next && (r_underflow_count != 16'hFFFF)) begin
            r_underflow_count <= r_underflow_count + 16'd1;
        end
    end

    assign underflow_count = r_underflow_count;
`else
    assign underflow_count = 16'h0000;
`endif

endmodule
